// File: rtl/dp_ram_if.sv
// Bus bundle for the dual-port synchronous RAM.
// Both request ports plus the status outputs travel together.
interface dp_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wd_a;
    logic              wen_a;
    logic [BE_W-1:0]   be_a;
    logic              ren_a;
    logic [DATA_W-1:0] rd_a;
    logic              rvalid_a;

    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wd_b;
    logic              wen_b;
    logic [BE_W-1:0]   be_b;
    logic              ren_b;
    logic [DATA_W-1:0] rd_b;
    logic              rvalid_b;

    logic              busy;
    logic              collision;

    modport master (
        output addr_a, wd_a, wen_a, be_a, ren_a,
        output addr_b, wd_b, wen_b, be_b, ren_b,
        input  rd_a, rvalid_a, rd_b, rvalid_b,
        input  busy, collision
    );

    modport slave (
        input  addr_a, wd_a, wen_a, be_a, ren_a,
        input  addr_b, wd_b, wen_b, be_b, ren_b,
        output rd_a, rvalid_a, rd_b, rvalid_b,
        output busy, collision
    );
endinterface

// File: rtl/dp_ram_sync.sv
// Synchronous true dual-port RAM with byte enables, registered reads,
// port-A-wins write arbitration and a post-reset clear sequencer.
module dp_ram_sync #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic   clk,
    input logic   rst,
    dp_ram_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic              coll_q, coll_d;

    logic              ready, in_a, in_b, same;
    logic [BE_W-1:0]   we_a, we_b;
    logic              wr_a, wr_b;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b, rdata_a, rdata_b;

    assign ready = (state_q == READY);
    assign in_a  = {1'b0, bus.addr_a} < DEPTH_X;
    assign in_b  = {1'b0, bus.addr_b} < DEPTH_X;
    assign same  = (bus.addr_a == bus.addr_b);
    assign we_a  = (ready && bus.wen_a && in_a) ? bus.be_a : '0;
    assign we_b  = (ready && bus.wen_b && in_b) ? bus.be_b : '0;
    assign wr_a  = |we_a;
    assign wr_b  = |we_b;
    assign old_a = mem[bus.addr_a];
    assign old_b = mem[bus.addr_b];

    // Byte merge; on a shared address both results carry A's bytes
    // over B's, so either write port stores the same word.
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < BE_W; i++) begin
            if (we_a[i])
                new_a[8*i +: 8] = bus.wd_a[8*i +: 8];
            else if (same && we_b[i])
                new_a[8*i +: 8] = bus.wd_b[8*i +: 8];
            if (same && we_a[i])
                new_b[8*i +: 8] = bus.wd_a[8*i +: 8];
            else if (we_b[i])
                new_b[8*i +: 8] = bus.wd_b[8*i +: 8];
        end
    end

    // Read data source: old word, or the merged word when writing first.
    always_comb begin
        rdata_a = old_a;
        rdata_b = old_b;
        if (RDW_MODE != 0) begin
            if (wr_a || (same && wr_b)) rdata_a = new_a;
            if (wr_b || (same && wr_a)) rdata_b = new_b;
        end
        if (!in_a) rdata_a = '0;
        if (!in_b) rdata_b = '0;
    end

    // Next state of the registered read ports and the collision flag.
    always_comb begin
        rvalid_a_d = ready && bus.ren_a;
        rvalid_b_d = ready && bus.ren_b;
        rd_a_d     = rvalid_a_d ? rdata_a : rd_a_q;
        rd_b_d     = rvalid_b_d ? rdata_b : rd_b_q;
        coll_d     = same && |(we_a & we_b);
    end

    // Storage: zero fill while clearing, merged user writes otherwise.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr_a) mem[bus.addr_a] <= new_a;
            if (wr_b) mem[bus.addr_b] <= new_b;
        end
    end

    // Clear sequencer: one word per cycle, then hand over to requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q   <= '0;
            busy_q  <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= READY;
                end
            endcase
        end
    end

    // Registered read outputs and collision pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            coll_q     <= coll_d;
        end
    end

    assign bus.rd_a      = rd_a_q;
    assign bus.rd_b      = rd_b_q;
    assign bus.rvalid_a  = rvalid_a_q;
    assign bus.rvalid_b  = rvalid_b_q;
    assign bus.collision = coll_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dp_ram_sync.sv
// Scoreboard bench: two RAM instances (256 words read-first and
// 200 words write-first) share one stimulus stream.
module tb_dp_ram_sync;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  aa, ab;
    logic [15:0] da, db;
    logic [1:0]  ba, bb;
    logic        wa, wb, ra, rb;

    dp_ram_if #(.DATA_W(16), .ADDR_W(8)) bus0 ();
    dp_ram_if #(.DATA_W(16), .ADDR_W(8)) bus1 ();

    assign bus0.addr_a = aa;  assign bus1.addr_a = aa;
    assign bus0.wd_a   = da;  assign bus1.wd_a   = da;
    assign bus0.wen_a  = wa;  assign bus1.wen_a  = wa;
    assign bus0.be_a   = ba;  assign bus1.be_a   = ba;
    assign bus0.ren_a  = ra;  assign bus1.ren_a  = ra;
    assign bus0.addr_b = ab;  assign bus1.addr_b = ab;
    assign bus0.wd_b   = db;  assign bus1.wd_b   = db;
    assign bus0.wen_b  = wb;  assign bus1.wen_b  = wb;
    assign bus0.be_b   = bb;  assign bus1.be_b   = bb;
    assign bus0.ren_b  = rb;  assign bus1.ren_b  = rb;

    dp_ram_sync #(.DATA_W(16), .ADDR_W(8), .DEPTH(256),
                  .RDW_MODE(0), .CLEAR_ON_RESET(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    dp_ram_sync #(.DATA_W(16), .ADDR_W(8), .DEPTH(200),
                  .RDW_MODE(1), .CLEAR_ON_RESET(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] mm [2][256];
    logic [15:0] q0a[$], q0b[$], q1a[$], q1b[$];
    logic        q0c[$], q1c[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rd(input string nm, input logic v, input logic [15:0] d,
                          input logic ev, input logic [15:0] e);
        n_chk++;
        if (v !== ev || (ev && d !== e)) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b data=%0h expected valid=%0b data=%0h at %0t",
                     nm, v, d, ev, e, $time);
        end
    endtask

    // Reference: every word zero after clear; B lands first, A on top.
    task automatic model_step(input int k, output logic [15:0] rva,
                              output logic [15:0] rvb, output logic c);
        int dep = (k == 0) ? 256 : 200;
        bit ina = int'(aa) < dep;
        bit inb = int'(ab) < dep;
        logic [15:0] olda = ina ? mm[k][aa] : 16'h0;
        logic [15:0] oldb = inb ? mm[k][ab] : 16'h0;
        for (int i = 0; i < 2; i++)
            if (wb && bb[i] && inb) mm[k][ab][8*i +: 8] = db[8*i +: 8];
        for (int i = 0; i < 2; i++)
            if (wa && ba[i] && ina) mm[k][aa][8*i +: 8] = da[8*i +: 8];
        rva = !ina ? 16'h0 : (k == 1) ? mm[k][aa] : olda;
        rvb = !inb ? 16'h0 : (k == 1) ? mm[k][ab] : oldb;
        c = wa && wb && ina && (aa == ab) && ((ba & bb) != 2'b00);
    endtask

    task automatic idle_sigs();
        wa = 0; wb = 0; ra = 0; rb = 0;
        aa = 0; ab = 0; da = 0; db = 0; ba = 0; bb = 0;
    endtask

    task automatic req(input logic wa_v, input logic [7:0] aa_v,
                       input logic [15:0] da_v, input logic [1:0] ba_v,
                       input logic ra_v, input logic wb_v,
                       input logic [7:0] ab_v, input logic [15:0] db_v,
                       input logic [1:0] bb_v, input logic rb_v);
        logic [15:0] r0a, r0b, r1a, r1b;
        logic c0, c1;
        wa = wa_v; aa = aa_v; da = da_v; ba = ba_v; ra = ra_v;
        wb = wb_v; ab = ab_v; db = db_v; bb = bb_v; rb = rb_v;
        model_step(0, r0a, r0b, c0);
        model_step(1, r1a, r1b, c1);
        @(posedge clk);
        if (ra) begin q0a.push_back(r0a); q1a.push_back(r1a); end
        if (rb) begin q0b.push_back(r0b); q1b.push_back(r1b); end
        q0c.push_back(c0);
        q1c.push_back(c1);
        #1;
        idle_sigs();
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mm[k][i] = 16'h0;
        q0a.delete(); q0b.delete(); q1a.delete(); q1b.delete();
        q0c.delete(); q1c.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd0a"}, 32'(bus0.rd_a), 0);
        chk({tag, "_rd0b"}, 32'(bus0.rd_b), 0);
        chk({tag, "_rv0"}, 32'({bus0.rvalid_a, bus0.rvalid_b}), 0);
        chk({tag, "_col0"}, 32'(bus0.collision), 0);
        chk({tag, "_busy0"}, 32'(bus0.busy), 1);
        chk({tag, "_rd1a"}, 32'(bus1.rd_a), 0);
        chk({tag, "_rd1b"}, 32'(bus1.rd_b), 0);
        chk({tag, "_rv1"}, 32'({bus1.rvalid_a, bus1.rvalid_b}), 0);
        chk({tag, "_col1"}, 32'(bus1.collision), 0);
        chk({tag, "_busy1"}, 32'(bus1.busy), 1);
    endtask

    // Counts busy cycles after release; junk requests must be ignored.
    task automatic wait_clear(input bit junk, input int limit);
        int c0 = 0, c1 = 0;
        for (int i = 1; i <= 400; i++) begin
            if (junk && i < 150) begin
                wa = 1'($urandom); wb = 1'($urandom);
                ra = 1'($urandom); rb = 1'($urandom);
                aa = 8'($urandom); ab = aa;
                da = 16'($urandom); db = 16'($urandom);
                ba = 2'b11; bb = 2'b11;
            end else begin
                idle_sigs();
            end
            @(posedge clk);
            #1;
            if (i == limit) begin
                rst = 1'b1;
                break;
            end
            if (c0 == 0 && !bus0.busy) c0 = i;
            if (c1 == 0 && !bus1.busy) c1 = i;
            if (c0 != 0 && c1 != 0) break;
        end
        idle_sigs();
        if (limit == 0) begin
            chk("busy0_cycles", 32'(c0), 256);
            chk("busy1_cycles", 32'(c1), 200);
        end
    endtask

    function automatic logic [7:0] pick_addr();
        if ($urandom_range(0, 9) == 0) return 8'($urandom_range(200, 255));
        return 8'(8'h40 + $urandom_range(0, 3));
    endfunction

    // Monitor: pops one expectation per presented read and per cycle's flag.
    always @(negedge clk) begin
        logic ev;
        logic [15:0] e;
        logic ec;
        if (!rst) begin
            ev = q0a.size() > 0; e = ev ? q0a.pop_front() : 16'h0;
            chk_rd("rd0_a", bus0.rvalid_a, bus0.rd_a, ev, e);
            ev = q0b.size() > 0; e = ev ? q0b.pop_front() : 16'h0;
            chk_rd("rd0_b", bus0.rvalid_b, bus0.rd_b, ev, e);
            ev = q1a.size() > 0; e = ev ? q1a.pop_front() : 16'h0;
            chk_rd("rd1_a", bus1.rvalid_a, bus1.rd_a, ev, e);
            ev = q1b.size() > 0; e = ev ? q1b.pop_front() : 16'h0;
            chk_rd("rd1_b", bus1.rvalid_b, bus1.rd_b, ev, e);
            ec = (q0c.size() > 0) ? q0c.pop_front() : 1'b0;
            chk("coll0", 32'(bus0.collision), 32'(ec));
            ec = (q1c.size() > 0) ? q1c.pop_front() : 1'b0;
            chk("coll1", 32'(bus1.collision), 32'(ec));
        end
    end

    initial begin
        idle_sigs();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst0");
        rst = 1'b0;
        wait_clear(0, 0);

        for (int i = 0; i < 256; i++)
            req(0, 8'(i), 0, 0, 1, 0, 8'(255 - i), 0, 0, 1);

        req(1, 8'h10, 16'hBEEF, 2'b11, 0, 0, 0, 0, 0, 0);
        req(0, 0, 0, 0, 0, 0, 8'h10, 0, 0, 1);

        req(1, 8'h20, 16'h1111, 2'b11, 0, 1, 8'h20, 16'h2222, 2'b11, 0);
        req(0, 8'h20, 0, 0, 1, 0, 0, 0, 0, 0);
        req(1, 8'h20, 16'h1111, 2'b01, 0, 1, 8'h20, 16'h2222, 2'b10, 0);
        req(0, 0, 0, 0, 0, 0, 8'h20, 0, 0, 1);

        req(1, 8'h30, 16'hAAAA, 2'b11, 0, 0, 0, 0, 0, 0);
        req(1, 8'h30, 16'h5555, 2'b11, 0, 0, 8'h30, 0, 0, 1);
        req(1, 8'h31, 16'h00C3, 2'b01, 1, 0, 0, 0, 0, 0);
        req(1, 8'h31, 16'h7700, 2'b00, 1, 0, 0, 0, 0, 1);

        req(1, 8'd250, 16'h1234, 2'b11, 0, 0, 0, 0, 0, 0);
        req(0, 8'd250, 0, 0, 1, 0, 8'd50, 0, 0, 1);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] a1;
            a1 = pick_addr();
            req(1'($urandom), a1, 16'($urandom), 2'($urandom), 1'($urandom),
                1'($urandom), ($urandom_range(0, 1) == 1) ? a1 : pick_addr(),
                16'($urandom), 2'($urandom), 1'($urandom));
        end

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset("rst_async");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear(1, 100);
        #1;
        chk_reset("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear(1, 0);

        for (int i = 0; i < 256; i++)
            req(0, 8'(i), 0, 0, 1, 0, 8'(i ^ 8'h5A), 0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained",
            32'(q0a.size() + q0b.size() + q1a.size() + q1b.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
